// File: rtl/pulse_train_generator.sv
// Pulse train generator.
// A one-cycle trigger starts a burst of PULSE_COUNT high phases, each
// PULSE_WIDTH cycles long, with GAP_WIDTH-cycle low phases between them.
// No gap follows the last pulse. A one-cycle done pulse marks normal
// completion.
//
// state | meaning
// IDLE  | waiting for a trigger; outputs low
// HIGH  | high phase of the current pulse
// GAP   | low phase between two pulses
module pulse_train_generator #(
  parameter int PULSE_WIDTH = 4,
  parameter int GAP_WIDTH   = 4,
  parameter int PULSE_COUNT = 3,
  parameter bit RETRIGGER   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  input  logic abort,
  output logic output_level,
  output logic busy,
  output logic done
);

  localparam int MAX_LEN = (PULSE_WIDTH > GAP_WIDTH) ? PULSE_WIDTH : GAP_WIDTH;
  // A phase length of 1 would give a zero-width counter; keep at least one bit.
  localparam int PH_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PC_W = $clog2(PULSE_COUNT + 1);

  localparam logic [PH_W-1:0] PH_HIGH_LAST = PH_W'(PULSE_WIDTH - 1);
  localparam logic [PH_W-1:0] PH_GAP_LAST  = PH_W'(GAP_WIDTH - 1);
  localparam logic [PC_W-1:0] PC_LAST      = PC_W'(PULSE_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [PH_W-1:0] phase_cnt, phase_next;
  logic [PC_W-1:0] pulse_cnt, pulse_next;
  logic            done_next;

  // Next-state and counter logic; abort wins over everything, then trigger.
  always_comb begin
    state_next = state;
    phase_next = phase_cnt;
    pulse_next = pulse_cnt;
    done_next  = 1'b0;
    if (abort) begin
      state_next = IDLE;
      phase_next = '0;
      pulse_next = '0;
    end else if (state == IDLE) begin
      if (trigger) begin
        state_next = HIGH;
        phase_next = '0;
        pulse_next = '0;
      end
    end else if (trigger && RETRIGGER) begin
      // Restart: the abandoned train never reports done.
      state_next = HIGH;
      phase_next = '0;
      pulse_next = '0;
    end else if (state == HIGH) begin
      if (phase_cnt == PH_HIGH_LAST) begin
        phase_next = '0;
        if (pulse_cnt == PC_LAST) begin
          state_next = IDLE;
          pulse_next = '0;
          done_next  = 1'b1;
        end else begin
          state_next = GAP;
          pulse_next = pulse_cnt + 1'b1;
        end
      end else begin
        phase_next = phase_cnt + 1'b1;
      end
    end else if (state == GAP) begin
      if (phase_cnt == PH_GAP_LAST) begin
        state_next = HIGH;
        phase_next = '0;
      end else begin
        phase_next = phase_cnt + 1'b1;
      end
    end else begin
      state_next = IDLE;
      phase_next = '0;
      pulse_next = '0;
    end
  end

  // State, counters and registered outputs; outputs are decoded from the
  // next state so they line up with the state register without extra delay.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      pulse_cnt    <= '0;
      output_level <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_next;
      phase_cnt    <= phase_next;
      pulse_cnt    <= pulse_next;
      output_level <= (state_next == HIGH);
      busy         <= (state_next != IDLE);
      done         <= done_next;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator. Three instances cover the
// ignore-retrigger, retrigger and single-pulse parameter sets. Bit c of each
// expected vector is the value required in cycle c (cycle c+1 follows edge c).
module tb_pulse_train_generator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic trig_a = 1'b0, abort_a = 1'b0, out_a, busy_a, done_a;
  logic trig_r = 1'b0, abort_r = 1'b0, out_r, busy_r, done_r;
  logic trig_s = 1'b0, abort_s = 1'b0, out_s, busy_s, done_s;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pulse_train_generator #(.PULSE_WIDTH(3), .GAP_WIDTH(2), .PULSE_COUNT(2), .RETRIGGER(1'b0)) dut_a (
    .clk(clk), .rst(rst), .trigger(trig_a), .abort(abort_a),
    .output_level(out_a), .busy(busy_a), .done(done_a));

  pulse_train_generator #(.PULSE_WIDTH(3), .GAP_WIDTH(2), .PULSE_COUNT(2), .RETRIGGER(1'b1)) dut_r (
    .clk(clk), .rst(rst), .trigger(trig_r), .abort(abort_r),
    .output_level(out_r), .busy(busy_r), .done(done_r));

  pulse_train_generator #(.PULSE_WIDTH(3), .GAP_WIDTH(1), .PULSE_COUNT(1), .RETRIGGER(1'b0)) dut_s (
    .clk(clk), .rst(rst), .trigger(trig_s), .abort(abort_s),
    .output_level(out_s), .busy(busy_s), .done(done_s));

  // Stimulus/recording only: drives trigger/abort of one instance from the
  // vectors (bit c applied at edge c) and records its outputs per cycle.
  task automatic run_vec(input int sel, input logic [31:0] trg, input logic [31:0] abt,
                         output logic [31:0] ao, output logic [31:0] ab, output logic [31:0] ad);
    ao = '0; ab = '0; ad = '0;
    @(negedge clk);
    for (int c = 0; c < 31; c++) begin
      case (sel)
        0: begin trig_a = trg[c]; abort_a = abt[c]; end
        1: begin trig_r = trg[c]; abort_r = abt[c]; end
        default: begin trig_s = trg[c]; abort_s = abt[c]; end
      endcase
      if (c == 0) begin
        case (sel)
          0: begin ao[0] = out_a; ab[0] = busy_a; ad[0] = done_a; end
          1: begin ao[0] = out_r; ab[0] = busy_r; ad[0] = done_r; end
          default: begin ao[0] = out_s; ab[0] = busy_s; ad[0] = done_s; end
        endcase
      end
      @(posedge clk);
      #1;
      case (sel)
        0: begin ao[c+1] = out_a; ab[c+1] = busy_a; ad[c+1] = done_a; end
        1: begin ao[c+1] = out_r; ab[c+1] = busy_r; ad[c+1] = done_r; end
        default: begin ao[c+1] = out_s; ab[c+1] = busy_s; ad[c+1] = done_s; end
      endcase
    end
    trig_a = 1'b0; abort_a = 1'b0;
    trig_r = 1'b0; abort_r = 1'b0;
    trig_s = 1'b0; abort_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_cmp++;
    if ({out_a, busy_a, done_a, out_r, busy_r, done_r, out_s, busy_s, done_s} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_state: got %b required 000000000",
               {out_a, busy_a, done_a, out_r, busy_r, done_r, out_s, busy_s, done_s});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] ao, ab, ad;
    run_vec(0, 32'h1, 32'h0, ao, ab, ad);
    for (int c = 0; c < 32; c++) begin
      n_cmp += 3;
      if (ao[c] !== (32'h1CE >> c) % 2) begin n_bad++; $display("FAIL basic_out cycle %0d: got %b", c, ao[c]); end
      if (ab[c] !== (32'h1FE >> c) % 2) begin n_bad++; $display("FAIL basic_busy cycle %0d: got %b", c, ab[c]); end
      if (ad[c] !== (32'h200 >> c) % 2) begin n_bad++; $display("FAIL basic_done cycle %0d: got %b", c, ad[c]); end
    end
  endtask

  task automatic test_ignored_retrigger();
    logic [31:0] ao, ab, ad;
    run_vec(0, 32'h11, 32'h0, ao, ab, ad);
    for (int c = 0; c < 32; c++) begin
      n_cmp += 3;
      if (ao[c] !== (32'h1CE >> c) % 2) begin n_bad++; $display("FAIL ignore_out cycle %0d: got %b", c, ao[c]); end
      if (ab[c] !== (32'h1FE >> c) % 2) begin n_bad++; $display("FAIL ignore_busy cycle %0d: got %b", c, ab[c]); end
      if (ad[c] !== (32'h200 >> c) % 2) begin n_bad++; $display("FAIL ignore_done cycle %0d: got %b", c, ad[c]); end
    end
  endtask

  task automatic test_retrigger();
    logic [31:0] ao, ab, ad;
    run_vec(1, 32'h11, 32'h0, ao, ab, ad);
    for (int c = 0; c < 32; c++) begin
      n_cmp += 3;
      if (ao[c] !== (32'h1CEE >> c) % 2) begin n_bad++; $display("FAIL retrig_out cycle %0d: got %b", c, ao[c]); end
      if (ab[c] !== (32'h1FFE >> c) % 2) begin n_bad++; $display("FAIL retrig_busy cycle %0d: got %b", c, ab[c]); end
      if (ad[c] !== (32'h2000 >> c) % 2) begin n_bad++; $display("FAIL retrig_done cycle %0d: got %b", c, ad[c]); end
    end
  endtask

  task automatic test_level_hold();
    logic [31:0] ao, ab, ad;
    run_vec(1, 32'h3FF, 32'h0, ao, ab, ad);
    for (int c = 0; c < 32; c++) begin
      n_cmp += 3;
      if (ao[c] !== (32'h39FFE >> c) % 2) begin n_bad++; $display("FAIL hold_out cycle %0d: got %b", c, ao[c]); end
      if (ab[c] !== (32'h3FFFE >> c) % 2) begin n_bad++; $display("FAIL hold_busy cycle %0d: got %b", c, ab[c]); end
      if (ad[c] !== (32'h40000 >> c) % 2) begin n_bad++; $display("FAIL hold_done cycle %0d: got %b", c, ad[c]); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] ao, ab, ad;
    run_vec(0, 32'h5, 32'h4, ao, ab, ad);
    for (int c = 0; c < 32; c++) begin
      n_cmp += 3;
      if (ao[c] !== (32'h6 >> c) % 2) begin n_bad++; $display("FAIL abort_out cycle %0d: got %b", c, ao[c]); end
      if (ab[c] !== (32'h6 >> c) % 2) begin n_bad++; $display("FAIL abort_busy cycle %0d: got %b", c, ab[c]); end
      if (ad[c] !== 1'b0) begin n_bad++; $display("FAIL abort_done cycle %0d: got %b required 0", c, ad[c]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ao, ab, ad;
    run_vec(0, 32'h201, 32'h0, ao, ab, ad);
    for (int c = 0; c < 32; c++) begin
      n_cmp += 3;
      if (ao[c] !== (32'h39DCE >> c) % 2) begin n_bad++; $display("FAIL b2b_out cycle %0d: got %b", c, ao[c]); end
      if (ab[c] !== (32'h3FDFE >> c) % 2) begin n_bad++; $display("FAIL b2b_busy cycle %0d: got %b", c, ab[c]); end
      if (ad[c] !== (32'h40200 >> c) % 2) begin n_bad++; $display("FAIL b2b_done cycle %0d: got %b", c, ad[c]); end
    end
  endtask

  task automatic test_reset_mid_train();
    @(negedge clk);
    trig_a = 1'b1;
    @(posedge clk);
    #1 trig_a = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({out_a, busy_a} !== 2'b11) begin
      n_bad++;
      $display("FAIL midrst_before: got out/busy %b required 11", {out_a, busy_a});
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_a, busy_a, done_a} !== 3'b000) begin
      n_bad++;
      $display("FAIL midrst_async: got %b required 000", {out_a, busy_a, done_a});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_a, busy_a, done_a} !== 3'b000) begin
        n_bad++;
        $display("FAIL midrst_after cycle %0d: got %b required 000", c, {out_a, busy_a, done_a});
      end
    end
  endtask

  task automatic test_single_pulse();
    logic [31:0] ao, ab, ad;
    run_vec(2, 32'h1, 32'h0, ao, ab, ad);
    for (int c = 0; c < 32; c++) begin
      n_cmp += 3;
      if (ao[c] !== (32'hE >> c) % 2) begin n_bad++; $display("FAIL single_out cycle %0d: got %b", c, ao[c]); end
      if (ab[c] !== (32'hE >> c) % 2) begin n_bad++; $display("FAIL single_busy cycle %0d: got %b", c, ab[c]); end
      if (ad[c] !== (32'h10 >> c) % 2) begin n_bad++; $display("FAIL single_done cycle %0d: got %b", c, ad[c]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored_retrigger();
    test_retrigger();
    test_level_hold();
    test_abort();
    test_back_to_back();
    test_reset_mid_train();
    test_single_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
